instruction_fetch_unit: RTL and testbench

Initiator side of the program-memory interface: owns the program counter, drives the 16-bit address into the combinational instruction ROM, registers the returned 28-bit word, and presents decoded fields to the ALU/register-file stage. It handles stalls, taken branches (with flush), halt, and optional timed-NOP delay. It sits between the instruction ROM and the execute stage of the core.

---
 rtl/instruction_fetch_unit_pkg.sv | 48 ++++
 rtl/instruction_fetch_unit_if.sv | 9 +
 rtl/instruction_fetch_unit_wait_counter.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 139 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode and register
// constants, FSM state encodings, instruction field bit positions and
// small decode helpers.
package instruction_fetch_unit_pkg;

  // Opcode constants shared with the execute stage
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_LDI = 8'h03;
  localparam logic [7:0] OP_JMP = 8'h04;

  // Register-address constants
  localparam logic [7:0] REG_R0 = 8'd0;
  localparam logic [7:0] REG_R1 = 8'd1;
  localparam logic [7:0] REG_SP = 8'd254;
  localparam logic [7:0] REG_LR = 8'd255;

  // Fetch FSM state encodings
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Field bit positions within the 28-bit instruction word
  localparam int OP_MSB   = 27;
  localparam int OP_LSB   = 20;
  localparam int DST_MSB  = 19;
  localparam int DST_LSB  = 12;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 8;
  localparam int SRC0_MSB = 7;
  localparam int SRC0_LSB = 0;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;
  localparam int CNT_MSB  = 23;
  localparam int CNT_LSB  = 0;

  // True when the word carries the NOP opcode
  function automatic logic is_nop(input logic [27:0] word);
    return (word[OP_MSB:OP_LSB] == OP_NOP);
  endfunction

  // Delay count carried in the low bits of a NOP word
  function automatic logic [23:0] nop_count(input logic [27:0] word);
    return word[CNT_MSB:CNT_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Program-memory bus between the fetch unit (master) and the
// combinational instruction ROM (slave).
interface instruction_fetch_unit_if;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;

  modport master (output oAddress, input iInstruction);
  modport slave  (input oAddress, output iInstruction);
endinterface

// File: rtl/instruction_fetch_unit_wait_counter.sv
// fetch_wait_counter: 24-bit loadable down-counter used to time the WAIT
// state after a counted NOP. done is raised while the count is at its
// last step, so the FSM leaves WAIT on that edge.
module fetch_wait_counter (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        load,
  input  logic [23:0] load_value,
  input  logic        dec,
  output logic        done
);

  logic [23:0] count_r;

  // Load on NOP entry, otherwise count down while waiting
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_r <= 24'd0;
    end else if (load) begin
      count_r <= load_value;
    end else if (dec) begin
      count_r <= count_r - 24'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r <= 24'd1);

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches from a combinational ROM,
// registers the word and presents decoded fields to the execute stage.
// Optional feature macro: FETCH_NOP_WAIT_EN (counted NOPs stall fetch in
// a WAIT state). Without it every NOP is a single-cycle bubble.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'd0
) (
  input  logic                       Clock,
  input  logic                       Reset,
  instruction_fetch_unit_if.master   rom,
  input  logic                       iStall,
  input  logic                       iBranchTaken,
  input  logic [15:0]                iBranchTarget,
  input  logic                       iHalt,
  output logic                       oValid,
  output logic [7:0]                 oOperation,
  output logic [7:0]                 oDestination,
  output logic [7:0]                 oSourceAddr1,
  output logic [7:0]                 oSourceAddr0,
  output logic [15:0]                oImmediate,
  output logic                       oHalted
);

  logic [15:0] pc_r, pc_s;
  logic [27:0] ir_r, ir_s;
  logic        valid_r, valid_s;
  logic [1:0]  state_r, state_s;
  logic        halted_r;
  logic        nop_s;

  assign nop_s = is_nop(rom.iInstruction);

`ifdef FETCH_NOP_WAIT_EN
  logic        wait_load_s;
  logic        wait_dec_s;
  logic        wait_done_s;
  logic [23:0] nop_count_s;
  logic [23:0] wait_value_s;

  assign nop_count_s  = nop_count(rom.iInstruction);
  // The NOP's own bubble cycle is the first of the N idle cycles
  assign wait_value_s = nop_count_s - 24'd1;

  fetch_wait_counter u_wait_counter (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (wait_load_s),
    .load_value (wait_value_s),
    .dec        (wait_dec_s),
    .done       (wait_done_s)
  );
`endif

  // Next-state logic: halt > branch > stall > fetch
  always_comb begin
    pc_s    = pc_r;
    ir_s    = ir_r;
    valid_s = valid_r;
    state_s = state_r;
`ifdef FETCH_NOP_WAIT_EN
    wait_load_s = 1'b0;
    wait_dec_s  = 1'b0;
`endif
    case (state_r)
      ST_RUN: begin
        if (iHalt) begin
          state_s = ST_HALT;
          valid_s = 1'b0;
        end else if (iBranchTaken) begin
          pc_s    = iBranchTarget;
          valid_s = 1'b0;
        end else if (iStall) begin
          pc_s    = pc_r;
        end else begin
          ir_s    = rom.iInstruction;
          pc_s    = pc_r + 16'd1;
          valid_s = ~nop_s;
`ifdef FETCH_NOP_WAIT_EN
          if (nop_s && (nop_count_s > 24'd1)) begin
            state_s     = ST_WAIT;
            wait_load_s = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
`endif
        end
      end
`ifdef FETCH_NOP_WAIT_EN
      ST_WAIT: begin
        valid_s = 1'b0;
        if (iHalt) begin
          state_s = ST_HALT;
        end else if (wait_done_s) begin
          state_s = ST_RUN;
        end else begin
          wait_dec_s = 1'b1;
        end
      end
`endif
      ST_HALT: begin
        state_s = ST_HALT;
        valid_s = 1'b0;
      end
      default: begin
        state_s = ST_RUN;
        valid_s = 1'b0;
      end
    endcase
  end

  // State, PC and instruction register update
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_r     <= RESET_PC;
      ir_r     <= 28'd0;
      valid_r  <= 1'b0;
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
    end else begin
      pc_r     <= pc_s;
      ir_r     <= ir_s;
      valid_r  <= valid_s;
      state_r  <= state_s;
      halted_r <= (state_s == ST_HALT);
    end
  end

  assign rom.oAddress = pc_r;
  assign oValid       = valid_r;
  assign oOperation   = ir_r[OP_MSB:OP_LSB];
  assign oDestination = ir_r[DST_MSB:DST_LSB];
  assign oSourceAddr1 = ir_r[SRC1_MSB:SRC1_LSB];
  assign oSourceAddr0 = ir_r[SRC0_MSB:SRC0_LSB];
  assign oImmediate   = ir_r[IMM_MSB:IMM_LSB];
  assign oHalted      = halted_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. The ROM holds
// {8'h11, 4'hA, addr} at every address except a counted NOP at 0x20.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iStall = 1'b0;
  logic        iBranchTaken = 1'b0;
  logic [15:0] iBranchTarget = 16'd0;
  logic        iHalt = 1'b0;
  logic        oValid, oHalted;
  logic [7:0]  oOperation, oDestination, oSourceAddr1, oSourceAddr0;
  logic [15:0] oImmediate;
  logic [27:0] rom_mem [0:65535];
  int          errors = 0;
  int          checks = 0;

  instruction_fetch_unit_if rom_bus ();
  assign rom_bus.iInstruction = rom_mem[rom_bus.oAddress];

  instruction_fetch_unit dut (
    .Clock(Clock), .Reset(Reset), .rom(rom_bus.master),
    .iStall(iStall), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .iHalt(iHalt), .oValid(oValid), .oOperation(oOperation),
    .oDestination(oDestination), .oSourceAddr1(oSourceAddr1),
    .oSourceAddr0(oSourceAddr0), .oImmediate(oImmediate), .oHalted(oHalted)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iHalt = 1'b0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rom_bus.oAddress !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected %h", rom_bus.oAddress, 16'h0000); end
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", oValid); end
    checks++; if ({oOperation, oDestination, oSourceAddr1, oSourceAddr0, oImmediate} !== 48'd0) begin errors++; $display("FAIL reset_fields: got %h expected 0", {oOperation, oDestination, oSourceAddr1, oSourceAddr0, oImmediate}); end
    checks++; if (oHalted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", oHalted); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      checks++; if (rom_bus.oAddress !== 16'(k)) begin errors++; $display("FAIL seq_addr: got %h expected %h", rom_bus.oAddress, 16'(k)); end
      tick();
      checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL seq_valid: got %b expected 1", oValid); end
      checks++; if ({oOperation, oDestination, oSourceAddr1, oSourceAddr0, oImmediate} !== {8'h11, 8'hA0, 8'h00, 8'(k), 16'(k)}) begin
        errors++; $display("FAIL seq_fields: got %h expected %h", {oOperation, oDestination, oSourceAddr1, oSourceAddr0, oImmediate}, {8'h11, 8'hA0, 8'h00, 8'(k), 16'(k)});
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (5) tick();
    iStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (rom_bus.oAddress !== 16'h0005) begin errors++; $display("FAIL stall_addr: got %h expected 0005", rom_bus.oAddress); end
      checks++; if (oImmediate !== 16'h0004 || oValid !== 1'b1) begin errors++; $display("FAIL stall_hold: got imm=%h valid=%b expected imm=0004 valid=1", oImmediate, oValid); end
    end
    iStall = 1'b0;
    tick();
    checks++; if (rom_bus.oAddress !== 16'h0006 || oImmediate !== 16'h0005) begin errors++; $display("FAIL stall_resume: got addr=%h imm=%h expected 0006/0005", rom_bus.oAddress, oImmediate); end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (7) tick();
    checks++; if (rom_bus.oAddress !== 16'h0007) begin errors++; $display("FAIL br_start: got %h expected 0007", rom_bus.oAddress); end
    iBranchTaken = 1'b1; iBranchTarget = 16'h0010; iStall = 1'b1;
    tick();
    iBranchTaken = 1'b0; iStall = 1'b0;
    checks++; if (rom_bus.oAddress !== 16'h0010 || oValid !== 1'b0) begin errors++; $display("FAIL br_redirect: got addr=%h valid=%b expected 0010/0", rom_bus.oAddress, oValid); end
    tick();
    checks++; if (rom_bus.oAddress !== 16'h0011 || oValid !== 1'b1 || oImmediate !== 16'h0010) begin errors++; $display("FAIL br_target_word: got addr=%h valid=%b imm=%h expected 0011/1/0010", rom_bus.oAddress, oValid, oImmediate); end
  endtask

  task automatic test_wrap();
    do_reset();
    iBranchTaken = 1'b1; iBranchTarget = 16'hFFFF;
    tick();
    iBranchTaken = 1'b0;
    checks++; if (rom_bus.oAddress !== 16'hFFFF) begin errors++; $display("FAIL wrap_target: got %h expected FFFF", rom_bus.oAddress); end
    tick();
    checks++; if (rom_bus.oAddress !== 16'h0000 || oImmediate !== 16'hFFFF || oValid !== 1'b1) begin errors++; $display("FAIL wrap_pc: got addr=%h imm=%h valid=%b expected 0000/FFFF/1", rom_bus.oAddress, oImmediate, oValid); end
  endtask

  task automatic test_nop();
    do_reset();
    iBranchTaken = 1'b1; iBranchTarget = 16'h0020;
    tick();
    iBranchTaken = 1'b0;
    tick();
    checks++; if (rom_bus.oAddress !== 16'h0021 || oValid !== 1'b0 || oOperation !== OP_NOP || oImmediate !== 16'h0004) begin
      errors++; $display("FAIL nop_fetch: got addr=%h valid=%b op=%h imm=%h expected 0021/0/00/0004", rom_bus.oAddress, oValid, oOperation, oImmediate);
    end
`ifdef FETCH_NOP_WAIT_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (rom_bus.oAddress !== 16'h0021 || oValid !== 1'b0) begin errors++; $display("FAIL nop_wait: got addr=%h valid=%b expected 0021/0", rom_bus.oAddress, oValid); end
    end
`endif
    tick();
    checks++; if (rom_bus.oAddress !== 16'h0022 || oValid !== 1'b1 || oImmediate !== 16'h0021) begin errors++; $display("FAIL nop_resume: got addr=%h valid=%b imm=%h expected 0022/1/0021", rom_bus.oAddress, oValid, oImmediate); end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (3) tick();
    iHalt = 1'b1;
    tick();
    iHalt = 1'b0;
    checks++; if (oHalted !== 1'b1 || oValid !== 1'b0 || rom_bus.oAddress !== 16'h0003) begin errors++; $display("FAIL halt_enter: got halted=%b valid=%b addr=%h expected 1/0/0003", oHalted, oValid, rom_bus.oAddress); end
    iBranchTaken = 1'b1; iBranchTarget = 16'h0040;
    repeat (2) begin
      tick();
      checks++; if (oHalted !== 1'b1 || oValid !== 1'b0 || rom_bus.oAddress !== 16'h0003) begin errors++; $display("FAIL halt_hold: got halted=%b valid=%b addr=%h expected 1/0/0003", oHalted, oValid, rom_bus.oAddress); end
    end
    iBranchTaken = 1'b0;
    do_reset();
    checks++; if (oHalted !== 1'b0 || oValid !== 1'b0 || rom_bus.oAddress !== 16'h0000) begin errors++; $display("FAIL halt_reset: got halted=%b valid=%b addr=%h expected 0/0/0000", oHalted, oValid, rom_bus.oAddress); end
    tick();
    checks++; if (rom_bus.oAddress !== 16'h0001 || oValid !== 1'b1) begin errors++; $display("FAIL halt_restart: got addr=%h valid=%b expected 0001/1", rom_bus.oAddress, oValid); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) rom_mem[a] = {8'h11, 4'hA, 16'(a)};
    rom_mem[16'h0020] = {OP_NOP, 20'd4};
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_wrap();
    test_nop();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
